// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to packed DxFxF sliding windows for the window FIFO
module conv_window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 3,
    parameter int F          = 3,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [D*DATA_WIDTH-1:0]       in_data,
    output logic                          in_ready,
    input  logic                          stall,
    output logic                          write,
    output logic [D*F*F*DATA_WIDTH-1:0]   data_out,
    output logic                          frame_done
);

    localparam int PW = D * DATA_WIDTH;
    localparam int WW = D * F * F * DATA_WIDTH;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] line_mem [F-1][IMG_W];
    logic [PW-1:0] new_col [F];
    logic [WW-1:0] win;
    logic [WW-1:0] win_next;
    logic          take;
    logic          emit;
    logic          last_col;
    logic          last_row;

    assign in_ready = ~stall;
    assign take     = in_valid & ~stall & ~clear;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    // Only windows fully inside the current frame and line are emitted.
    assign emit     = take & (row >= RW'(F - 1)) & (col >= CW'(F - 1));

    // Incoming column, oldest line at the top (r=0), live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < F; r++) begin
            new_col[r] = '0;
        end
        for (int r = 0; r < F - 1; r++) begin
            new_col[r] = line_mem[F-2-r][col];
        end
        new_col[F-1] = in_data;
    end

    always_comb begin
        win_next = win;
        for (int c = 0; c < D; c++) begin
            for (int r = 0; r < F; r++) begin
                for (int k = 0; k < F; k++) begin
                    if (k < F - 1) begin
                        win_next[((c*F+r)*F+k)*DATA_WIDTH +: DATA_WIDTH] =
                            win[((c*F+r)*F+k+1)*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        win_next[((c*F+r)*F+k)*DATA_WIDTH +: DATA_WIDTH] =
                            new_col[r][c*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Line memories carry no reset; stale rows are masked by the row gate on emit.
    always_ff @(posedge clk) begin
        if (take) begin
            line_mem[0][col] <= in_data;
            for (int i = 1; i < F - 1; i++) begin
                line_mem[i][col] <= line_mem[i-1][col];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            win        <= '0;
            write      <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            write      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            write      <= emit;
            frame_done <= emit & last_row & last_col;
            if (emit) begin
                data_out <= win_next;
            end
            if (take) begin
                win <= win_next;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - scoreboard bench for conv_window_gen, small directed and default random frames
module tb_conv_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // small instance: D=1, F=3, 5x4
    logic         s_clear, s_valid, s_stall, s_ready, s_write, s_fd;
    logic [15:0]  s_data;
    logic [143:0] s_dout;

    // default instance: D=3, F=3, 256x256
    logic         b_clear, b_valid, b_stall, b_ready, b_write, b_fd;
    logic [47:0]  b_data;
    logic [431:0] b_dout;

    conv_window_gen #(.DATA_WIDTH(16), .D(1), .F(3), .IMG_W(5), .IMG_H(4)) u_small (
        .clk(clk), .reset(reset), .clear(s_clear), .in_valid(s_valid), .in_data(s_data),
        .in_ready(s_ready), .stall(s_stall), .write(s_write), .data_out(s_dout),
        .frame_done(s_fd)
    );

    conv_window_gen u_big (
        .clk(clk), .reset(reset), .clear(b_clear), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .stall(b_stall), .write(b_write), .data_out(b_dout),
        .frame_done(b_fd)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [144:0] s_q [$];
    int           s_cq [$];
    logic [432:0] b_q [$];
    int s_wr_cnt = 0, s_fd_cnt = 0, b_wr_cnt = 0, b_fd_cnt = 0;
    int srow = 0, scol = 0;
    bit stog = 1'b0;
    logic s_stall_q = 1'b0;
    logic [47:0] img [65536];

    function automatic logic [15:0] spix(input int r, input int c);
        return 16'(r * 16 + c);
    endfunction

    function automatic logic [143:0] s_exp_win(input int r, input int c);
        logic [143:0] w;
        for (int rr = 0; rr < 3; rr++)
            for (int k = 0; k < 3; k++)
                w[(rr*3+k)*16 +: 16] = spix(r - 2 + rr, c - 2 + k);
        return w;
    endfunction

    function automatic logic [431:0] b_exp_win(input int r, input int c);
        logic [431:0] w;
        logic [47:0]  p;
        for (int ch = 0; ch < 3; ch++)
            for (int rr = 0; rr < 3; rr++)
                for (int k = 0; k < 3; k++) begin
                    p = img[(r - 2 + rr) * 256 + (c - 2 + k)];
                    w[((ch*3+rr)*3+k)*16 +: 16] = p[ch*16 +: 16];
                end
        return w;
    endfunction

    always @(posedge clk) s_stall_q <= s_stall;

    always @(negedge clk) begin
        logic [144:0] e;
        int pc;
        if (s_stall_q) check("s_wr_after_stall", s_write, 1'b0);
        if (s_write) begin
            s_wr_cnt++;
            if (s_fd) s_fd_cnt++;
            if (s_q.size() == 0) begin
                check("s_unexpected_wr", 1'b1, 1'b0);
            end else begin
                e  = s_q.pop_front();
                pc = s_cq.pop_front();
                check("s_window", s_dout, e[143:0]);
                check("s_frame_done", s_fd, e[144]);
                check("s_latency", cyc, pc + 1);
            end
        end else if (s_fd) begin
            check("s_fd_without_wr", 1'b1, 1'b0);
        end
    end

    always @(negedge clk) begin
        logic [432:0] e;
        if (b_write) begin
            b_wr_cnt++;
            if (b_fd) b_fd_cnt++;
            if (b_q.size() == 0) begin
                check("b_unexpected_wr", 1'b1, 1'b0);
            end else begin
                e = b_q.pop_front();
                check("b_window", b_dout, e[431:0]);
                check("b_frame_done", b_fd, e[432]);
            end
        end
    end

    task automatic run_pixels(input int n, input bit stall_mode);
        int done = 0;
        while (done < n) begin
            @(negedge clk);
            s_clear = 1'b0;
            s_valid = 1'b1;
            s_data  = spix(srow, scol);
            s_stall = stall_mode && (srow >= 2) && stog;
            stog    = ~stog;
            if (!s_stall) begin
                if (srow >= 2 && scol >= 2) begin
                    s_q.push_back({(srow == 3 && scol == 4), s_exp_win(srow, scol)});
                    s_cq.push_back(cyc);
                end
                done++;
                if (scol == 4) begin
                    scol = 0;
                    srow = (srow == 3) ? 0 : srow + 1;
                end else begin
                    scol++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_stall = 1'b0;
            s_clear = 1'b0;
        end
    endtask

    task automatic expect_counts(input string tag, input int bw, input int bf, input int nw, input int nf);
        check({tag, "_writes"}, s_wr_cnt - bw, nw);
        check({tag, "_frame_done"}, s_fd_cnt - bf, nf);
        check({tag, "_queue_empty"}, s_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int bw, bf;
        logic [47:0] px;
        reset = 1'b0;
        s_clear = 0; s_valid = 0; s_stall = 0; s_data = '0;
        b_clear = 0; b_valid = 0; b_stall = 0; b_data = '0;
        #12;
        check("rst_write", s_write, 1'b0);
        check("rst_data_out", s_dout, '0);
        check("rst_frame_done", s_fd, 1'b0);
        check("rst_b_data_out", b_dout, '0);
        s_stall = 1'b1;
        #1 check("ready_stalled", s_ready, 1'b0);
        s_stall = 1'b0;
        #1 check("ready_free", s_ready, 1'b1);
        @(negedge clk) reset = 1'b1;

        bw = s_wr_cnt; bf = s_fd_cnt;
        run_pixels(20, 1'b0);
        idle(3);
        expect_counts("full", bw, bf, 6, 1);

        bw = s_wr_cnt; bf = s_fd_cnt;
        run_pixels(20, 1'b1);
        idle(3);
        expect_counts("stall", bw, bf, 6, 1);

        bw = s_wr_cnt; bf = s_fd_cnt;
        run_pixels(40, 1'b0);
        idle(3);
        expect_counts("b2b", bw, bf, 12, 2);

        run_pixels(14, 1'b0);
        @(posedge clk);
        #1 check("pre_reset_write", s_write, 1'b1);
        #1 reset = 1'b0;
        s_valid = 1'b0;
        #1 check("async_rst_write", s_write, 1'b0);
        check("async_rst_data_out", s_dout, '0);
        s_q.delete();
        s_cq.delete();
        srow = 0; scol = 0;
        @(negedge clk) reset = 1'b1;
        bw = s_wr_cnt; bf = s_fd_cnt;
        run_pixels(20, 1'b0);
        idle(3);
        expect_counts("after_reset", bw, bf, 6, 1);

        run_pixels(17, 1'b0);
        @(negedge clk);
        s_valid = 1'b1; s_stall = 1'b0; s_clear = 1'b1; s_data = spix(3, 2);
        srow = 0; scol = 0;
        @(posedge clk);
        #1 check("clear_no_write", s_write, 1'b0);
        bw = s_wr_cnt; bf = s_fd_cnt;
        run_pixels(20, 1'b0);
        idle(3);
        expect_counts("after_clear", bw, bf, 6, 1);

        for (int r = 0; r < 256; r++) begin
            for (int c = 0; c < 256; c++) begin
                @(negedge clk);
                px = {16'($urandom()), 32'($urandom())};
                img[r * 256 + c] = px;
                b_valid = 1'b1;
                b_data  = px;
                if (r >= 2 && c >= 2)
                    b_q.push_back({(r == 255 && c == 255), b_exp_win(r, c)});
            end
        end
        @(negedge clk) b_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("big_writes", b_wr_cnt, 64516);
        check("big_frame_done", b_fd_cnt, 1);
        check("big_queue_empty", b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
